synapse_array: RTL

Multi-input, weighted-sum successor to the single-weight synapse. It holds a register file of N_INPUTS programmable weights and accepts one packed input vector per transaction. It accumulates the products serially, one channel per cycle, then scales, saturates and presents one neuron-drive value over a valid/ready handshake. It sits between the input spike/data fabric and the neuron integrator.

---
 rtl/synapse_array.sv | 122 ++++++++++++
 1 files changed

// File: rtl/synapse_array.sv
// Weighted-sum synapse: N programmable weights, serial MAC over one packed input vector,
// then shift / saturate, with the result offered on a valid/ready handshake.
module synapse_array #(
    parameter int N_INPUTS = 4,
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int OUT_W    = 8,
    parameter int SHIFT    = 0,
    parameter int SATURATE = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         w_we_i,
    input  logic [$clog2(N_INPUTS)-1:0]  w_addr_i,
    input  logic [WEIGHT_W-1:0]          w_data_i,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [N_INPUTS*DATA_W-1:0]   data_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [OUT_W-1:0]             data_o,
    output logic                         sat_o
);
    localparam int IDX_W  = $clog2(N_INPUTS);
    localparam int PROD_W = DATA_W + WEIGHT_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam int EXT_W  = ACC_W + OUT_W;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

    state_t                       r_state;
    logic [IDX_W-1:0]             r_idx;
    logic [N_INPUTS*DATA_W-1:0]   r_x;
    logic [ACC_W-1:0]             r_acc;
    logic [WEIGHT_W-1:0]          r_w [N_INPUTS];
    logic [OUT_W-1:0]             r_data;
    logic                         r_sat;
    logic                         r_out_valid;
    logic                         r_in_ready;

    logic [DATA_W-1:0]            w_x;
    logic [PROD_W-1:0]            w_prod;
    logic [ACC_W-1:0]             w_acc_next;
    logic [EXT_W-1:0]             w_ext;
    logic                         w_over;
    logic [OUT_W-1:0]             w_result;
    logic                         w_last;

    // The final product is folded in combinationally so the result registers on the last ACCUM edge.
    always_comb begin
        w_x        = r_x[int'(r_idx)*DATA_W +: DATA_W];
        w_prod     = PROD_W'(w_x) * PROD_W'(r_w[r_idx]);
        w_acc_next = r_acc + ACC_W'(w_prod);
        w_ext      = EXT_W'(w_acc_next >> SHIFT);
        w_over     = |(w_ext >> OUT_W);
        w_result   = (w_over && (SATURATE != 0)) ? '1 : w_ext[OUT_W-1:0];
        w_last     = (r_idx == IDX_W'(N_INPUTS - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_x         <= '0;
            r_acc       <= '0;
            r_data      <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid_i) begin
                        r_x        <= data_i;
                        r_acc      <= '0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    r_acc <= w_acc_next;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_data      <= w_result;
                        r_sat       <= w_over;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    // A write lands at the end of its cycle, so the product in flight still sees the old weight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned k = 0; k < N_INPUTS; k++) r_w[k] <= '0;
        end else if (w_we_i && (int'(w_addr_i) < N_INPUTS)) begin
            r_w[w_addr_i] <= w_data_i;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = r_out_valid;
    assign data_o      = r_data;
    assign sat_o       = r_sat;
endmodule
